// File: rtl/vocoder_sequencer_if.sv
// Handshake bundle between the vocoder sequencer and the datapath stages it schedules.
`timescale 1ns/1ps
interface vocoder_sequencer_if;
  logic               sample_valid_in;
  logic               filt_start_out;
  logic               filt_car_done_in;
  logic               filt_mod_done_in;
  logic               env_start_out;
  logic               env_done_in;
  logic               mix_start_out;
  logic               mix_valid_in;
  logic signed [23:0] mixed_in;
  logic [4:0]         shift_out;
  logic               auto_gain_en_in;
  logic [4:0]         shift_manual_in;
  logic signed [23:0] audio_out;
  logic               audio_valid_out;
  logic               busy_out;
  logic [15:0]        overrun_count_out;
  logic               timeout_err_out;

  // Sequencer side
  modport master (
    input  sample_valid_in, filt_car_done_in, filt_mod_done_in, env_done_in,
           mix_valid_in, mixed_in, auto_gain_en_in, shift_manual_in,
    output filt_start_out, env_start_out, mix_start_out, shift_out, audio_out,
           audio_valid_out, busy_out, overrun_count_out, timeout_err_out
  );

  // Sample source / datapath side
  modport slave (
    output sample_valid_in, filt_car_done_in, filt_mod_done_in, env_done_in,
           mix_valid_in, mixed_in, auto_gain_en_in, shift_manual_in,
    input  filt_start_out, env_start_out, mix_start_out, shift_out, audio_out,
           audio_valid_out, busy_out, overrun_count_out, timeout_err_out
  );
endinterface

// File: rtl/vocoder_sequencer.sv
// Per-sample scheduler: filter banks -> envelopes -> mixer, with stage timeouts,
// overrun counting and auto-gain control of the mixer output shift.
`timescale 1ns/1ps
module vocoder_sequencer #(
  parameter int          TIMEOUT_CYCLES  = 4096,
  parameter logic [23:0] CLIP_THRESH     = 24'h7C0000,
  parameter logic [23:0] QUIET_THRESH    = 24'h100000,
  parameter int          RELEASE_SAMPLES = 256,
  parameter int          SHIFT_MIN       = 0
) (
  input logic               clk_in,
  input logic               rst_in,
  vocoder_sequencer_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int QW = $clog2(RELEASE_SAMPLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILTER, S_ENV, S_MIX} state_t;

  state_t             r_state, w_next;
  logic [TW-1:0]      r_timer;
  logic [QW-1:0]      r_quiet;
  logic               r_car, r_mod;
  logic               r_filt_start, r_env_start, r_mix_start, r_audio_v, r_to_err;
  logic signed [23:0] r_audio;
  logic [4:0]         r_shift;
  logic [15:0]        r_ovr;
  logic               w_accept, w_go_env, w_go_mix, w_done, w_to, w_timeout, w_overrun;
  logic [24:0]        w_mix_ext, w_abs;
  logic               w_clip, w_quiet;

  assign w_timeout = (r_timer == TW'(TIMEOUT_CYCLES - 1));
  assign w_overrun = bus.sample_valid_in && (r_state != S_IDLE);

  // 25-bit magnitude so that -2^23 maps to +2^23 instead of wrapping
  assign w_mix_ext = {bus.mixed_in[23], bus.mixed_in};
  assign w_abs     = w_mix_ext[24] ? -w_mix_ext : w_mix_ext;
  assign w_clip    = (w_abs >= {1'b0, CLIP_THRESH});
  assign w_quiet   = (w_abs <  {1'b0, QUIET_THRESH});

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_go_env = 1'b0;
    w_go_mix = 1'b0;
    w_done   = 1'b0;
    w_to     = 1'b0;
    case (r_state)
      S_IDLE: if (bus.sample_valid_in) begin
        w_accept = 1'b1;
        w_next   = S_FILTER;
      end
      S_FILTER:
        if ((r_car || bus.filt_car_done_in) && (r_mod || bus.filt_mod_done_in)) begin
          w_go_env = 1'b1;
          w_next   = S_ENV;
        end else if (w_timeout) begin
          w_to   = 1'b1;
          w_next = S_IDLE;
        end
      S_ENV:
        if (bus.env_done_in) begin
          w_go_mix = 1'b1;
          w_next   = S_MIX;
        end else if (w_timeout) begin
          w_to   = 1'b1;
          w_next = S_IDLE;
        end
      S_MIX:
        if (bus.mix_valid_in) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end else if (w_timeout) begin
          w_to   = 1'b1;
          w_next = S_IDLE;
        end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_timer      <= '0;
      r_quiet      <= '0;
      r_car        <= 1'b0;
      r_mod        <= 1'b0;
      r_filt_start <= 1'b0;
      r_env_start  <= 1'b0;
      r_mix_start  <= 1'b0;
      r_audio_v    <= 1'b0;
      r_audio      <= '0;
      r_shift      <= '0;
      r_ovr        <= '0;
      r_to_err     <= 1'b0;
    end else begin
      r_filt_start <= w_accept;
      r_env_start  <= w_go_env;
      r_mix_start  <= w_go_mix;
      r_audio_v    <= w_done;

      if (r_state != w_next)      r_timer <= '0;
      else if (r_state != S_IDLE) r_timer <= r_timer + 1'b1;

      if (w_accept) begin
        r_car <= 1'b0;
        r_mod <= 1'b0;
      end else if (r_state == S_FILTER) begin
        r_car <= r_car | bus.filt_car_done_in;
        r_mod <= r_mod | bus.filt_mod_done_in;
      end

      if (w_overrun && r_ovr != 16'hFFFF) r_ovr <= r_ovr + 1'b1;
      if (w_to) r_to_err <= 1'b1;
      if (w_done) r_audio <= bus.mixed_in;

      // Shift only moves on the IDLE accept or the edge leaving MIX
      if (w_accept && !bus.auto_gain_en_in) begin
        r_shift <= bus.shift_manual_in;
      end else if (w_done && bus.auto_gain_en_in) begin
        if (w_clip) begin
          if (r_shift != 5'd31) r_shift <= r_shift + 1'b1;
          r_quiet <= '0;
        end else if (w_quiet) begin
          if (r_quiet == QW'(RELEASE_SAMPLES - 1)) begin
            r_quiet <= '0;
            if (r_shift > 5'(SHIFT_MIN)) r_shift <= r_shift - 1'b1;
          end else begin
            r_quiet <= r_quiet + 1'b1;
          end
        end else begin
          r_quiet <= '0;
        end
      end
    end
  end

  assign bus.filt_start_out    = r_filt_start;
  assign bus.env_start_out     = r_env_start;
  assign bus.mix_start_out     = r_mix_start;
  assign bus.audio_out         = r_audio;
  assign bus.audio_valid_out   = r_audio_v;
  assign bus.shift_out         = r_shift;
  assign bus.busy_out          = (r_state != S_IDLE);
  assign bus.overrun_count_out = r_ovr;
  assign bus.timeout_err_out   = r_to_err;
endmodule

// File: tb/tb_vocoder_sequencer.sv
// Directed bench for vocoder_sequencer: scoreboard on audio output, pulse counters,
// auto-gain shift model, timeout, overrun saturation and mid-run reset.
`timescale 1ns/1ps
module tb_vocoder_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vocoder_sequencer_if vif();
  vocoder_sequencer dut (.clk_in(clk), .rst_in(rst), .bus(vif.master));

  int n_checks = 0;
  int n_fail   = 0;
  int n_filt = 0, n_env = 0, n_mix = 0, n_audio = 0;
  logic [23:0] sb[$];
  int model_shift = 0;
  int model_quiet = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse counters and scoreboard compare, sampled mid-cycle
  always @(negedge clk) begin
    if (vif.filt_start_out) n_filt++;
    if (vif.env_start_out)  n_env++;
    if (vif.mix_start_out)  n_mix++;
    if (vif.audio_valid_out) begin
      n_audio++;
      if (sb.size() == 0) chk("sb_unexpected_audio", 32'd1, 32'd0);
      else chk("audio_out", {8'h0, vif.audio_out[23:0]}, {8'h0, sb.pop_front()});
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_shift = 0;
    model_quiet = 0;
  endtask

  task automatic model_gain(input logic [23:0] mix);
    logic [24:0] e, a;
    e = {mix[23], mix};
    a = e[24] ? (25'd0 - e) : e;
    if (a >= 25'h07C0000) begin
      if (model_shift < 31) model_shift++;
      model_quiet = 0;
    end else if (a < 25'h0100000) begin
      model_quiet++;
      if (model_quiet == 256) begin
        model_quiet = 0;
        if (model_shift > 0) model_shift--;
      end
    end else model_quiet = 0;
  endtask

  task automatic run_sample(input logic [23:0] mix, input int dcar, input int dmod,
                            input int denv, input int dmix, input int novr);
    int f0, e0, m0, a0, maxd;
    f0 = n_filt; e0 = n_env; m0 = n_mix; a0 = n_audio;
    maxd = (dcar > dmod) ? dcar : dmod;
    if (!vif.auto_gain_en_in) model_shift = int'(vif.shift_manual_in);
    vif.sample_valid_in = 1'b1;
    tick();
    vif.sample_valid_in = 1'b0;
    chk("filt_start", 32'(vif.filt_start_out), 32'd1);
    for (int c = 1; c <= maxd; c++) begin
      vif.filt_car_done_in = (c == dcar);
      vif.filt_mod_done_in = (c == dmod);
      vif.sample_valid_in  = (c <= novr);
      tick();
    end
    vif.filt_car_done_in = 1'b0;
    vif.filt_mod_done_in = 1'b0;
    vif.sample_valid_in  = 1'b0;
    chk("env_start_next", 32'(vif.env_start_out), 32'd1);
    for (int c = 1; c <= denv; c++) begin
      vif.env_done_in = (c == denv);
      tick();
    end
    vif.env_done_in = 1'b0;
    chk("mix_start_next", 32'(vif.mix_start_out), 32'd1);
    for (int c = 1; c <= dmix; c++) begin
      vif.mix_valid_in = (c == dmix);
      vif.mixed_in     = (c == dmix) ? mix : 24'h0;
      if (c == dmix) sb.push_back(mix);
      tick();
    end
    vif.mix_valid_in = 1'b0;
    chk("audio_valid", 32'(vif.audio_valid_out), 32'd1);
    if (vif.auto_gain_en_in) model_gain(mix);
    tick();
    chk("busy_after", 32'(vif.busy_out), 32'd0);
    chk("pulse_counts", {8'(n_filt - f0), 8'(n_env - e0), 8'(n_mix - m0), 8'(n_audio - a0)},
        32'h01010101);
    chk("shift_model", 32'(vif.shift_out), 32'(model_shift));
  endtask

  initial begin
    int n, f0, e0, m0, a0;
    vif.sample_valid_in  = 1'b0;
    vif.filt_car_done_in = 1'b0;
    vif.filt_mod_done_in = 1'b0;
    vif.env_done_in      = 1'b0;
    vif.mix_valid_in     = 1'b0;
    vif.mixed_in         = 24'h0;
    vif.auto_gain_en_in  = 1'b0;
    vif.shift_manual_in  = 5'd5;
    do_reset();

    chk("rst_busy", 32'(vif.busy_out), 32'd0);
    chk("rst_pulses", {vif.filt_start_out, vif.env_start_out, vif.mix_start_out,
        vif.audio_valid_out}, 32'd0);
    chk("rst_audio", {8'h0, vif.audio_out[23:0]}, 32'd0);
    chk("rst_shift", 32'(vif.shift_out), 32'd0);
    chk("rst_overrun", 32'(vif.overrun_count_out), 32'd0);
    chk("rst_timeout", 32'(vif.timeout_err_out), 32'd0);

    // Manual shift, staggered stage latencies, then same-cycle filter dones
    run_sample(24'h123456, 10, 6, 5, 20, 0);
    chk("manual_shift", 32'(vif.shift_out), 32'd5);
    run_sample(24'hABCDEF, 3, 3, 2, 4, 0);
    vif.shift_manual_in = 5'd9;
    run_sample(24'h000001, 1, 4, 1, 1, 0);
    chk("manual_shift9", 32'(vif.shift_out), 32'd9);

    // Three strobes dropped during one busy run
    run_sample(24'h0F0F0F, 5, 5, 1, 1, 3);
    chk("overrun3", 32'(vif.overrun_count_out), 32'd3);

    // Auto-gain attack, including the most negative sample
    do_reset();
    vif.auto_gain_en_in = 1'b1;
    for (int i = 0; i < 3; i++) run_sample(24'h7FFFFF, 1, 1, 1, 1, 0);
    chk("auto_clip3", 32'(vif.shift_out), 32'd3);
    run_sample(24'h800000, 1, 1, 1, 1, 0);
    chk("auto_clip_neg", 32'(vif.shift_out), 32'd4);
    for (int i = 0; i < 28; i++) run_sample(24'h7FFFFF, 2, 1, 1, 1, 0);
    chk("auto_clip_hold31", 32'(vif.shift_out), 32'd31);

    // Auto-gain release: a mid-level sample restarts the quiet run
    do_reset();
    vif.auto_gain_en_in = 1'b1;
    for (int i = 0; i < 3; i++) run_sample(24'h7FFFFF, 1, 1, 1, 1, 0);
    for (int i = 0; i < 255; i++) run_sample(24'h000010, 1, 1, 1, 1, 0);
    run_sample(24'h200000, 1, 1, 1, 1, 0);
    chk("quiet_interrupted", 32'(vif.shift_out), 32'd3);
    for (int i = 0; i < 255; i++) run_sample(24'h000010, 1, 1, 1, 1, 0);
    chk("quiet_255", 32'(vif.shift_out), 32'd3);
    run_sample(24'h000010, 1, 1, 1, 1, 0);
    chk("quiet_256", 32'(vif.shift_out), 32'd2);

    // Withheld env_done: timeout after exactly TIMEOUT_CYCLES in ENVELOPE
    a0 = n_audio;
    vif.sample_valid_in = 1'b1;
    tick();
    vif.sample_valid_in  = 1'b0;
    vif.filt_car_done_in = 1'b1;
    vif.filt_mod_done_in = 1'b1;
    tick();
    vif.filt_car_done_in = 1'b0;
    vif.filt_mod_done_in = 1'b0;
    n = 0;
    while (!vif.timeout_err_out && n < 5000) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd4096);
    chk("timeout_err", 32'(vif.timeout_err_out), 32'd1);
    chk("timeout_idle", 32'(vif.busy_out), 32'd0);
    tick();
    chk("timeout_no_audio", 32'(n_audio - a0), 32'd0);

    // Continuous strobes with stalled filters: counter saturates
    vif.sample_valid_in = 1'b1;
    n = 0;
    while (vif.overrun_count_out != 16'hFFFF && n < 70000) begin
      tick();
      n++;
    end
    for (int i = 0; i < 20; i++) tick();
    vif.sample_valid_in = 1'b0;
    chk("overrun_sat", 32'(vif.overrun_count_out), 32'h0000FFFF);

    // Reset in the middle of FILTER: everything back to reset values, no late pulses
    do_reset();
    vif.auto_gain_en_in = 1'b0;
    vif.sample_valid_in = 1'b1;
    tick();
    vif.sample_valid_in  = 1'b0;
    vif.filt_car_done_in = 1'b1;
    tick();
    vif.filt_car_done_in = 1'b0;
    chk("pre_rst_busy", 32'(vif.busy_out), 32'd1);
    rst = 1'b1;
    tick();
    f0 = n_filt; e0 = n_env; m0 = n_mix; a0 = n_audio;
    chk("mid_rst_busy", 32'(vif.busy_out), 32'd0);
    chk("mid_rst_outs", {vif.filt_start_out, vif.env_start_out, vif.mix_start_out,
        vif.audio_valid_out, vif.timeout_err_out, vif.shift_out}, 32'd0);
    chk("mid_rst_audio", {8'h0, vif.audio_out[23:0]}, 32'd0);
    chk("mid_rst_overrun", 32'(vif.overrun_count_out), 32'd0);
    rst = 1'b0;
    vif.filt_mod_done_in = 1'b1;
    tick();
    vif.filt_mod_done_in = 1'b0;
    vif.env_done_in      = 1'b1;
    tick();
    vif.env_done_in  = 1'b0;
    vif.mix_valid_in = 1'b1;
    tick();
    vif.mix_valid_in = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("no_late_pulses", {8'(n_filt - f0), 8'(n_env - e0), 8'(n_mix - m0), 8'(n_audio - a0)},
        32'd0);
    chk("post_rst_busy", 32'(vif.busy_out), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
